vga_digit_field: RTL and testbench



---
 rtl/vga_digit_field.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_digit_field.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_digit_field.sv
// N-digit, 9-segment decimal field overlaid on the VGA pixel stream, 2-cycle latency.
// Optional VGA_DIGIT_BLINK_EN adds a frame-counted blink of the max highlight.
module vga_digit_field #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned X0           = 16,
  parameter int unsigned Y0           = 16,
  parameter int unsigned W            = 32,
  parameter int unsigned H            = 64,
  parameter int unsigned T            = 6,
  parameter int unsigned GAP          = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic                  pix_valid,
  input  logic                  frame_start,
  input  logic [4*DIGITS-1:0]   num_bcd,
  input  logic [3:0]            theme,
  input  logic                  max,
  output logic [11:0]           rgb,
  output logic                  rgb_valid
);

  localparam int unsigned LXW = $clog2(W);
  localparam int unsigned LYW = $clog2(H);

  localparam logic [LXW-1:0] LX_LO   = LXW'(T);
  localparam logic [LXW-1:0] LX_HI   = LXW'(W - T);
  localparam logic [LYW-1:0] LY_TOP  = LYW'(T);
  localparam logic [LYW-1:0] LY_BOT  = LYW'(H - T);
  localparam logic [LYW-1:0] LY_HALF = LYW'(H / 2);
  localparam logic [LYW-1:0] LY_MID0 = LYW'(H / 2 - T / 2);
  localparam logic [LYW-1:0] LY_MID1 = LYW'(H / 2 - T / 2 + T);

  if (W <= 2 * T || H <= 3 * T || BLINK_FRAMES < 1) begin : gen_bad_params
    $error("vga_digit_field: illegal geometry or blink period");
  end

  // {fg, bg}
  function automatic logic [23:0] pick_colours(input logic [3:0] th, input logic mx);
    logic [11:0] fg;
    logic [11:0] bg;
    case (th)
      4'd1:    begin fg = 12'h000; bg = 12'hfff; end
      4'd2:    begin fg = 12'h8f0; bg = 12'he7d; end
      4'd3:    begin fg = 12'h8f0; bg = 12'h000; end
      4'd4:    begin fg = 12'h0d5; bg = 12'hfff; end
      4'd5:    begin fg = 12'h37f; bg = 12'he7d; end
      default: begin fg = 12'hfff; bg = 12'h000; end
    endcase
    if (mx) begin
      fg = 12'hfe8;
      bg = (th == 4'd1) ? 12'hfff : (th == 4'd2) ? 12'he7d : 12'h000;
    end
    return {fg, bg};
  endfunction

  function automatic logic [8:0] seg_mask(input logic [3:0] code);
    case (code)
      4'd0:    seg_mask = 9'h03f;
      4'd1:    seg_mask = 9'h006;
      4'd2:    seg_mask = 9'h05b;
      4'd3:    seg_mask = 9'h04f;
      4'd4:    seg_mask = 9'h066;
      4'd5:    seg_mask = 9'h06d;
      4'd6:    seg_mask = 9'h07d;
      4'd7:    seg_mask = 9'h007;
      4'd8:    seg_mask = 9'h07f;
      4'd9:    seg_mask = 9'h06f;
      4'd11:   seg_mask = 9'h000;
      default: seg_mask = 9'h1c0;
    endcase
  endfunction

  // Frame shadows
  logic [4*DIGITS-1:0] num_sh;
  logic [3:0]          theme_sh;
  logic                max_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_sh   <= '0;
      theme_sh <= '0;
      max_sh   <= 1'b0;
    end else if (frame_start) begin
      num_sh   <= num_bcd;
      theme_sh <= theme;
      max_sh   <= max;
    end
  end

`ifdef VGA_DIGIT_BLINK_EN
  localparam int unsigned CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [CNTW-1:0] blink_cnt;
  logic            blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n || !max_sh) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == CNTW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`endif

  // Stage 0: leading-zero blanking, cell hit test, colour pick
  logic [3:0]     code_eff [DIGITS];
  logic           seen_nz;
  logic           col_hit;
  logic           row_hit;
  logic [3:0]     code_s0;
  logic [LXW-1:0] lx_s0;
  logic [LYW-1:0] ly_s0;
  logic [11:0]    fg_s0;
  logic [11:0]    bg_s0;

  always_comb begin
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      code_eff[i] = num_sh[4*i +: 4];
      if (num_sh[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz && i != 0) code_eff[i] = 4'd11;
    end
  end

  always_comb begin
    col_hit = 1'b0;
    code_s0 = 4'd11;
    lx_s0   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if ({1'b0, pix_x} >= 11'(X0 + k * (W + GAP)) &&
          {1'b0, pix_x} <  11'(X0 + k * (W + GAP) + W)) begin
        col_hit = 1'b1;
        code_s0 = code_eff[DIGITS-1-k];
        lx_s0   = LXW'(pix_x - 10'(X0 + k * (W + GAP)));
      end
    end
    row_hit = ({1'b0, pix_y} >= 11'(Y0)) && ({1'b0, pix_y} < 11'(Y0 + H));
    ly_s0   = LYW'(pix_y - 10'(Y0));
  end

  always_comb begin
    {fg_s0, bg_s0} = pick_colours(theme_sh, max_sh);
`ifdef VGA_DIGIT_BLINK_EN
    if (max_sh && !blink_phase) fg_s0 = bg_s0;
`endif
  end

  // Stage 1: everything the pixel needs is frozen here, so a shadow load in the
  // same cycle only affects later pixels.
  logic           vld_q;
  logic           in_q;
  logic [3:0]     code_q;
  logic [LXW-1:0] lx_q;
  logic [LYW-1:0] ly_q;
  logic [11:0]    fg_q;
  logic [11:0]    bg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      in_q   <= 1'b0;
      code_q <= 4'd11;
      lx_q   <= '0;
      ly_q   <= '0;
      fg_q   <= '0;
      bg_q   <= '0;
    end else begin
      vld_q  <= pix_valid;
      in_q   <= col_hit && row_hit;
      code_q <= code_s0;
      lx_q   <= lx_s0;
      ly_q   <= ly_s0;
      fg_q   <= fg_s0;
      bg_q   <= bg_s0;
    end
  end

  // Stage 2: segment rectangles against the lit set
  logic [8:0]  rect;
  logic        left;
  logic        right;
  logic        mid;
  logic        fg_pix;
  logic [11:0] rgb_d;

  always_comb begin
    left    = lx_q < LX_LO;
    right   = lx_q >= LX_HI;
    mid     = (ly_q >= LY_MID0) && (ly_q < LY_MID1);
    rect[0] = ly_q < LY_TOP;
    rect[1] = right && (ly_q < LY_HALF);
    rect[2] = right && (ly_q >= LY_HALF);
    rect[3] = ly_q >= LY_BOT;
    rect[4] = left && (ly_q >= LY_HALF);
    rect[5] = left && (ly_q < LY_HALF);
    rect[6] = mid && !left && !right;
    rect[7] = mid && left;
    rect[8] = mid && right;
    fg_pix  = in_q && |(rect & seg_mask(code_q));
    rgb_d   = vld_q ? (fg_pix ? fg_q : bg_q) : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb       <= 12'h000;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= rgb_d;
      rgb_valid <= vld_q;
    end
  end

endmodule

// File: tb/tb_vga_digit_field.sv
// Directed bench for vga_digit_field; blink expectations follow VGA_DIGIT_BLINK_EN.
module tb_vga_digit_field;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic        frame_start;
  logic [15:0] num_bcd;
  logic [3:0]  theme;
  logic        max;
  logic [11:0] rgb;
  logic        rgb_valid;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vga_digit_field dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .num_bcd     (num_bcd),
    .theme       (theme),
    .max         (max),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One pixel through the 2-cycle pipe
  task automatic render(input int x, input int y, output logic [11:0] c, output logic v);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    c = rgb;
    v = rgb_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    nvec++;
    if (rgb !== 12'h000) begin
      nerr++;
      $display("FAIL reset_rgb: got %h want 000", rgb);
    end
    nvec++;
    if (rgb_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valid: got %b want 0", rgb_valid);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_digits();
    int          xs[5] = '{30, 110, 124, 150, 16};
    int          ys[5] = '{18, 18, 30, 46, 100};
    logic [11:0] ex[5] = '{12'h000, 12'h000, 12'hfff, 12'hfff, 12'h000};
    logic [11:0] c;
    logic        v;
    theme = 4'd0; num_bcd = 16'h0042; max = 1'b0;
    fs();
    for (int i = 0; i < 5; i++) begin
      render(xs[i], ys[i], c, v);
      nvec++;
      if (c !== ex[i] || v !== 1'b1) begin
        nerr++;
        $display("FAIL digits(%0d,%0d): got %h/%b want %h/1", xs[i], ys[i], c, v, ex[i]);
      end
    end
  endtask

  task automatic test_shadow();
    logic [11:0] c;
    logic        v;
    num_bcd = 16'h0000;
    render(124, 30, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL shadow_hold: got %h want fff", c);
    end
    fs();
    render(124, 30, c, v);
    nvec++;
    if (c !== 12'h000) begin
      nerr++;
      $display("FAIL shadow_load: got %h want 000", c);
    end
    render(136, 16, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL zero_top: got %h want fff", c);
    end
    render(150, 46, c, v);
    nvec++;
    if (c !== 12'h000) begin
      nerr++;
      $display("FAIL zero_middle: got %h want 000", c);
    end
  endtask

  task automatic test_coincident();
    logic [11:0] c;
    logic        v;
    num_bcd     = 16'h0008;
    frame_start = 1'b1;
    pix_x = 10'd150; pix_y = 10'd46; pix_valid = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    tick();
    nvec++;
    if (rgb !== 12'h000) begin
      nerr++;
      $display("FAIL coincident_old: got %h want 000", rgb);
    end
    render(150, 46, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL coincident_new: got %h want fff", c);
    end
  endtask

  task automatic test_latency();
    logic [11:0] c;
    logic        v;
    theme = 4'd1; num_bcd = 16'h8888; max = 1'b0;
    fs();
    render(16, 16, c, v);
    nvec++;
    if (c !== 12'h000) begin
      nerr++;
      $display("FAIL t1_corner: got %h want 000", c);
    end
    render(50, 16, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL t1_gap: got %h want fff", c);
    end
    tick();
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    nvec++;
    if (rgb_valid !== 1'b0) begin
      nerr++;
      $display("FAIL lat_1: got %b want 0", rgb_valid);
    end
    tick();
    nvec++;
    if (rgb_valid !== 1'b1 || rgb !== 12'hfff) begin
      nerr++;
      $display("FAIL lat_2: got %b/%h want 1/fff", rgb_valid, rgb);
    end
    tick();
    nvec++;
    if (rgb_valid !== 1'b0 || rgb !== 12'h000) begin
      nerr++;
      $display("FAIL lat_3: got %b/%h want 0/000", rgb_valid, rgb);
    end
  endtask

  task automatic test_themes();
    logic [11:0] fgs[5] = '{12'h8f0, 12'h8f0, 12'h0d5, 12'h37f, 12'hfff};
    logic [11:0] bgs[5] = '{12'he7d, 12'h000, 12'hfff, 12'he7d, 12'h000};
    logic [11:0] c;
    logic        v;
    num_bcd = 16'h0008; max = 1'b0;
    for (int t = 2; t <= 6; t++) begin
      theme = 4'(t);
      fs();
      render(136, 16, c, v);
      nvec++;
      if (c !== fgs[t-2]) begin
        nerr++;
        $display("FAIL theme%0d_fg: got %h want %h", t, c, fgs[t-2]);
      end
      render(50, 16, c, v);
      nvec++;
      if (c !== bgs[t-2]) begin
        nerr++;
        $display("FAIL theme%0d_bg: got %h want %h", t, c, bgs[t-2]);
      end
    end
    theme = 4'd2; max = 1'b1;
    fs();
    render(136, 16, c, v);
    nvec++;
    if (c !== 12'hfe8) begin
      nerr++;
      $display("FAIL max_fg: got %h want fe8", c);
    end
    render(50, 16, c, v);
    nvec++;
    if (c !== 12'he7d) begin
      nerr++;
      $display("FAIL max_bg: got %h want e7d", c);
    end
    max = 1'b0;
    fs();
  endtask

  task automatic test_max_blink();
    logic [11:0] c;
    logic [11:0] ex;
    logic        v;
    theme = 4'd1; num_bcd = 16'h0008; max = 1'b1;
    for (int f = 0; f < 62; f++) begin
      fs();
      render(136, 16, c, v);
`ifdef VGA_DIGIT_BLINK_EN
      ex = ((f / 30) % 2 == 0) ? 12'hfe8 : 12'hfff;
`else
      ex = 12'hfe8;
`endif
      if (f == 0 || f == 29 || f == 30 || f == 59 || f == 60 || f == 61) begin
        nvec++;
        if (c !== ex) begin
          nerr++;
          $display("FAIL blink_frame%0d: got %h want %h", f, c, ex);
        end
      end
    end
    max = 1'b0;
    for (int f = 0; f < 2; f++) begin
      fs();
      render(136, 16, c, v);
      nvec++;
      if (c !== 12'h000) begin
        nerr++;
        $display("FAIL max_off%0d: got %h want 000", f, c);
      end
    end
  endtask

  task automatic test_codes();
    int          xs[3] = '{136, 150, 136};
    int          ys[3] = '{16, 46, 40};
    logic [11:0] c;
    logic        v;
    theme = 4'd0; max = 1'b0; num_bcd = 16'h000b;
    fs();
    for (int i = 0; i < 3; i++) begin
      render(xs[i], ys[i], c, v);
      nvec++;
      if (c !== 12'h000) begin
        nerr++;
        $display("FAIL blank(%0d,%0d): got %h want 000", xs[i], ys[i], c);
      end
    end
    num_bcd = 16'h000c;
    fs();
    render(150, 46, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL dash_mid: got %h want fff", c);
    end
    render(136, 46, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL dash_left: got %h want fff", c);
    end
    render(150, 16, c, v);
    nvec++;
    if (c !== 12'h000) begin
      nerr++;
      $display("FAIL dash_top: got %h want 000", c);
    end
    render(150, 30, c, v);
    nvec++;
    if (c !== 12'h000) begin
      nerr++;
      $display("FAIL dash_upper: got %h want 000", c);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] c;
    logic        v;
    theme = 4'd2; num_bcd = 16'h8888; max = 1'b0;
    fs();
    pix_x = 10'd16; pix_y = 10'd16; pix_valid = 1'b1;
    tick();
    tick();
    nvec++;
    if (rgb !== 12'h8f0 || rgb_valid !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset: got %h/%b want 8f0/1", rgb, rgb_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nvec++;
    if (rgb !== 12'h000 || rgb_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_out1: got %h/%b want 000/0", rgb, rgb_valid);
    end
    tick();
    nvec++;
    if (rgb !== 12'h000 || rgb_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_out2: got %h/%b want 000/0", rgb, rgb_valid);
    end
    tick();
    pix_valid = 1'b0;
    nvec++;
    if (rgb !== 12'h000 || rgb_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rst_shadow_blank: got %h/%b want 000/1", rgb, rgb_valid);
    end
    render(136, 16, c, v);
    nvec++;
    if (c !== 12'hfff) begin
      nerr++;
      $display("FAIL rst_shadow_zero: got %h want fff", c);
    end
    fs();
    render(16, 16, c, v);
    nvec++;
    if (c !== 12'h8f0) begin
      nerr++;
      $display("FAIL rst_reload: got %h want 8f0", c);
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_x = '0; pix_y = '0; pix_valid = 1'b0; frame_start = 1'b0;
    num_bcd = '0; theme = '0; max = 1'b0;
    test_reset();
    test_digits();
    test_shadow();
    test_coincident();
    test_latency();
    test_themes();
    test_max_blink();
    test_codes();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
